// File: rtl/d8m_pkg.sv
// Shared definitions for the D8M raw-domain blocks: CFA site codes,
// frame-sync FSM encoding and the pixel/line counter width.
package d8m_pkg;

  localparam int CNT_W = 11;

  typedef enum logic [1:0] {
    CFA_G0 = 2'b00,
    CFA_R  = 2'b01,
    CFA_B  = 2'b10,
    CFA_G1 = 2'b11
  } cfa_e;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2
  } sync_state_e;

endpackage

// File: rtl/rgb2raw_bayer_if.sv
// RGB input stream and raw Bayer output stream of the re-mosaic encoder.
interface rgb2raw_bayer_if;
  import d8m_pkg::*;

  logic [7:0]       iRed;
  logic [7:0]       iGreen;
  logic [7:0]       iBlue;
  logic             iDVAL;
  logic             VGA_VS;
  logic             VGA_HS;
  logic [9:0]       oDATA;
  logic             oDVAL;
  logic             oFVAL;
  logic             oLVAL;
  logic             oSOF;
  logic [CNT_W-1:0] oX;
  logic [CNT_W-1:0] oY;

  modport master (
    output iRed, iGreen, iBlue, iDVAL, VGA_VS, VGA_HS,
    input  oDATA, oDVAL, oFVAL, oLVAL, oSOF, oX, oY
  );

  modport slave (
    input  iRed, iGreen, iBlue, iDVAL, VGA_VS, VGA_HS,
    output oDATA, oDVAL, oFVAL, oLVAL, oSOF, oX, oY
  );

endinterface

// File: rtl/bayer_pos_counter.sv
// Column/line position tracker: saturating X/Y counters, HS edge detect and
// the phase-adjusted CFA position of the current pixel.
module bayer_pos_counter
  import d8m_pkg::*;
#(
  parameter logic [1:0] BAYER_PHASE = 2'b00,
  parameter int         X_MAX       = 2047,
  parameter int         Y_MAX       = 2047
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vs,
  input  logic             hs,
  input  logic             adv,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic [1:0]       p
);

  localparam logic [CNT_W-1:0] XM = CNT_W'(X_MAX);
  localparam logic [CNT_W-1:0] YM = CNT_W'(Y_MAX);

  logic hs_prev;

  // A line only counts if it carried a pixel, so Y looks at X before it clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      x       <= '0;
      y       <= '0;
      hs_prev <= 1'b0;
    end else begin
      hs_prev <= hs;
      if (!vs) begin
        x <= '0;
        y <= '0;
      end else begin
        if (!hs)
          x <= '0;
        else if (adv && (x != XM))
          x <= x + 1'b1;
        if (hs_prev && !hs && (x != '0) && (y != YM))
          y <= y + 1'b1;
      end
    end
  end

  assign p = {y[0] ^ BAYER_PHASE[1], x[0] ^ BAYER_PHASE[0]};

endmodule

// File: rtl/rgb2raw_bayer.sv
// RGB888 to 10-bit Bayer raw re-mosaic encoder: frame-sync FSM, two-stage
// pipeline selecting the CFA colour and widening it by MSB replication.
module rgb2raw_bayer
  import d8m_pkg::*;
#(
  parameter logic [1:0] BAYER_PHASE = 2'b00,
  parameter int         X_MAX       = 2047,
  parameter int         Y_MAX       = 2047
) (
  input  logic          VGA_CLK,
  input  logic          RST,
  rgb2raw_bayer_if.slave bus
);

  sync_state_e      state, state_nxt;
  logic             accept, fwd, sof_pend, sof_hit;
  logic [CNT_W-1:0] x_cur, y_cur;
  logic [1:0]       pos_cur;

  logic [7:0]       r_p0, g_p0, b_p0, sel_p0;
  logic [CNT_W-1:0] x_p0, y_p0;
  cfa_e             pos_p0;
  logic             vld_p0, sof_p0, vs_p0, hs_p0;

  logic [9:0]       data_p1;
  logic [CNT_W-1:0] x_p1, y_p1;
  logic             vld_p1, sof_p1, vs_p1, hs_p1;

  function automatic logic [9:0] expand10(input logic [7:0] c);
    return {c, c[7:6]};
  endfunction

  assign accept  = bus.iDVAL & bus.VGA_VS & bus.VGA_HS;
  assign fwd     = accept & (state == ACTIVE);
  assign sof_hit = fwd & sof_pend & (x_cur == '0) & (y_cur == '0);

  always_ff @(posedge VGA_CLK) begin
    if (RST) state <= SYNC;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SYNC:    if (!bus.VGA_VS) state_nxt = ARMED;
      ARMED:   if (bus.VGA_VS)  state_nxt = ACTIVE;
      ACTIVE:  if (!bus.VGA_VS) state_nxt = ARMED;
      default: state_nxt = SYNC;
    endcase
  end

  // Re-armed on every frame entry so a frame yields at most one SOF.
  always_ff @(posedge VGA_CLK) begin
    if (RST)
      sof_pend <= 1'b0;
    else if ((state == ARMED) && bus.VGA_VS)
      sof_pend <= 1'b1;
    else if (sof_hit)
      sof_pend <= 1'b0;
  end

  bayer_pos_counter #(
    .BAYER_PHASE (BAYER_PHASE),
    .X_MAX       (X_MAX),
    .Y_MAX       (Y_MAX)
  ) u_pos (
    .clk (VGA_CLK),
    .rst (RST),
    .vs  (bus.VGA_VS),
    .hs  (bus.VGA_HS),
    .adv (fwd),
    .x   (x_cur),
    .y   (y_cur),
    .p   (pos_cur)
  );

  // ---- stage p0: capture colours, position and qualifiers ----
  always_ff @(posedge VGA_CLK) begin
    if (RST) begin
      vld_p0 <= 1'b0;
      sof_p0 <= 1'b0;
      vs_p0  <= 1'b0;
      hs_p0  <= 1'b0;
    end else begin
      vld_p0 <= fwd;
      sof_p0 <= sof_hit;
      vs_p0  <= bus.VGA_VS;
      hs_p0  <= bus.VGA_HS;
    end
  end

  always_ff @(posedge VGA_CLK) begin
    if (fwd) begin
      r_p0   <= bus.iRed;
      g_p0   <= bus.iGreen;
      b_p0   <= bus.iBlue;
      x_p0   <= x_cur;
      y_p0   <= y_cur;
      pos_p0 <= cfa_e'(pos_cur);
    end
  end

  always_comb begin
    sel_p0 = g_p0;
    case (pos_p0)
      CFA_R:   sel_p0 = r_p0;
      CFA_B:   sel_p0 = b_p0;
      default: sel_p0 = g_p0;
    endcase
  end

  // ---- stage p1: output registers, cleared by reset so every output is 0 ----
  always_ff @(posedge VGA_CLK) begin
    if (RST) begin
      vld_p1  <= 1'b0;
      sof_p1  <= 1'b0;
      vs_p1   <= 1'b0;
      hs_p1   <= 1'b0;
      data_p1 <= '0;
      x_p1    <= '0;
      y_p1    <= '0;
    end else begin
      vld_p1 <= vld_p0;
      sof_p1 <= sof_p0;
      vs_p1  <= vs_p0;
      hs_p1  <= hs_p0;
      if (vld_p0) begin
        data_p1 <= expand10(sel_p0);
        x_p1    <= x_p0;
        y_p1    <= y_p0;
      end
    end
  end

  assign bus.oDATA = data_p1;
  assign bus.oDVAL = vld_p1;
  assign bus.oSOF  = sof_p1;
  assign bus.oFVAL = vs_p1;
  assign bus.oLVAL = hs_p1;
  assign bus.oX    = x_p1;
  assign bus.oY    = y_p1;

endmodule

// File: tb/tb_rgb2raw_bayer.sv
// Scoreboard bench for rgb2raw_bayer: two instances (phase 00 and 11) share one
// stimulus stream; a frame-level reference model predicts every output sample.
module tb_rgb2raw_bayer;
  import d8m_pkg::*;

  localparam int XMAX = 2047;
  localparam int YMAX = 2047;
  localparam int HMSK = 16383;
  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rgb2raw_bayer_if bus0 ();
  rgb2raw_bayer_if bus1 ();

  rgb2raw_bayer #(.BAYER_PHASE(2'b00), .X_MAX(XMAX), .Y_MAX(YMAX)) dut0 (
    .VGA_CLK (clk),
    .RST     (rst),
    .bus     (bus0)
  );

  rgb2raw_bayer #(.BAYER_PHASE(2'b11), .X_MAX(XMAX), .Y_MAX(YMAX)) dut1 (
    .VGA_CLK (clk),
    .RST     (rst),
    .bus     (bus1)
  );

  typedef struct {
    int         stamp;
    logic [9:0] d0;
    logic [9:0] d1;
    int         x;
    int         y;
    bit         sof;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mon_k;
  bit   ef, el;
  bit   vs_h [HMSK+1];
  bit   hs_h [HMSK+1];
  bit   rst_h[HMSK+1];

  // reference model state
  bit m_armed, m_active, m_pend, m_hsprev;
  int m_x, m_y;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, expv, cyc);
    end
  endtask

  // Colour seen at CFA site (x,y): G R / B G pattern shifted by phase, widened to 10 bits.
  function automatic logic [9:0] expect_raw(input int x, input int y, input logic [1:0] ph,
                                            input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b);
    int row, col, c;
    row = (y + int'(ph[1])) % 2;
    col = (x + int'(ph[0])) % 2;
    if (row == 0 && col == 1)      c = int'(r);
    else if (row == 1 && col == 0) c = int'(b);
    else                           c = int'(g);
    return 10'(c * 4 + c / 64);
  endfunction

  task automatic step(input bit r_, input bit vs, input bit hs, input bit dv,
                      input logic [7:0] cr, input logic [7:0] cg, input logic [7:0] cb);
    exp_t e;
    bit   fwd;
    @(posedge clk);
    #1;
    rst = r_;
    bus0.VGA_VS = vs; bus0.VGA_HS = hs; bus0.iDVAL = dv;
    bus0.iRed = cr; bus0.iGreen = cg; bus0.iBlue = cb;
    bus1.VGA_VS = vs; bus1.VGA_HS = hs; bus1.iDVAL = dv;
    bus1.iRed = cr; bus1.iGreen = cg; bus1.iBlue = cb;
    vs_h[cyc & HMSK]  = vs;
    hs_h[cyc & HMSK]  = hs;
    rst_h[cyc & HMSK] = r_;
    if (r_) begin
      m_armed = 0; m_active = 0; m_pend = 0; m_hsprev = 0; m_x = 0; m_y = 0;
      // samples accepted in the cycle before reset never reach the output
      while (sbq.size() > 0 && sbq[$].stamp >= cyc + 1) void'(sbq.pop_back());
    end else begin
      fwd = dv && vs && hs && m_active;
      if (fwd) begin
        e.stamp = cyc + 2;
        e.x     = m_x;
        e.y     = m_y;
        e.sof   = m_pend && m_x == 0 && m_y == 0;
        if (e.sof) m_pend = 0;
        e.d0 = expect_raw(m_x, m_y, 2'b00, cr, cg, cb);
        e.d1 = expect_raw(m_x, m_y, 2'b11, cr, cg, cb);
        sbq.push_back(e);
        if (m_x < XMAX) m_x++;
      end
      if (!vs) begin
        m_x = 0; m_y = 0;
      end else if (!hs) begin
        if (m_hsprev && m_x != 0 && m_y < YMAX) m_y++;
        m_x = 0;
      end
      m_hsprev = hs;
      if (!vs) begin
        m_armed = 1; m_active = 0;
      end else if (m_armed) begin
        m_armed = 0; m_active = 1; m_pend = 1;
      end
    end
  endtask

  // mode 0: iDVAL always high, 1: toggling 1,0,1,0, 2: random gaps
  task automatic frame(input int w, input int h, input int mode,
                       input logic [7:0] cr, input logic [7:0] cg, input logic [7:0] cb,
                       input bit rnd, input bit abrupt);
    bit dv, tog;
    logic [7:0] r, g, b;
    int n;
    r = cr; g = cg; b = cb;
    repeat (3) step(L, L, L, L, 8'h0, 8'h0, 8'h0);
    repeat (2) step(L, H, L, L, 8'h0, 8'h0, 8'h0);
    for (int ln = 0; ln < h; ln++) begin
      n = 0;
      tog = 1'b1;
      while (n < w) begin
        if (mode == 0)      dv = 1'b1;
        else if (mode == 1) dv = tog;
        else                dv = 1'($urandom_range(0, 1));
        tog = ~tog;
        if (rnd) begin
          r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
        end
        step(L, H, H, dv, r, g, b);
        if (dv) n++;
      end
      if (!(abrupt && ln == h - 1)) repeat (2) step(L, H, L, L, 8'h0, 8'h0, 8'h0);
    end
  endtask

  task automatic do_reset(input bit vs, input bit hs);
    step(H, vs, hs, L, 8'h0, 8'h0, 8'h0);
    step(L, vs, hs, L, 8'h0, 8'h0, 8'h0);
    @(negedge clk);
    chk("rst_odata0", bus0.oDATA, 0);
    chk("rst_odval0", bus0.oDVAL, 0);
    chk("rst_osof0",  bus0.oSOF,  0);
    chk("rst_ofval0", bus0.oFVAL, 0);
    chk("rst_olval0", bus0.oLVAL, 0);
    chk("rst_ox0",    bus0.oX,    0);
    chk("rst_oy0",    bus0.oY,    0);
    chk("rst_odata1", bus1.oDATA, 0);
    chk("rst_odval1", bus1.oDVAL, 0);
  endtask

  // Monitor: pops the scoreboard whenever a sample is presented.
  always @(negedge clk) begin
    mon_k = cyc;
    if (mon_k >= 2) begin
      ef = vs_h[(mon_k-2) & HMSK] && !rst_h[(mon_k-2) & HMSK] && !rst_h[(mon_k-1) & HMSK];
      el = hs_h[(mon_k-2) & HMSK] && !rst_h[(mon_k-2) & HMSK] && !rst_h[(mon_k-1) & HMSK];
      chk("ofval0", bus0.oFVAL, ef);
      chk("olval0", bus0.oLVAL, el);
      chk("ofval1", bus1.oFVAL, ef);
      chk("olval1", bus1.oLVAL, el);
    end
    while (sbq.size() > 0 && sbq[0].stamp < mon_k) begin
      mon_e = sbq.pop_front();
      chk("missing_sample_cycle", 0, mon_e.stamp);
    end
    if (bus0.oDVAL || bus1.oDVAL) begin
      if (sbq.size() == 0 || sbq[0].stamp != mon_k) begin
        chk("spurious_odval", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        chk("odval0", bus0.oDVAL, 1);
        chk("odval1", bus1.oDVAL, 1);
        chk("odata0", bus0.oDATA, mon_e.d0);
        chk("odata1", bus1.oDATA, mon_e.d1);
        chk("ox0",    bus0.oX,    mon_e.x);
        chk("oy0",    bus0.oY,    mon_e.y);
        chk("ox1",    bus1.oX,    mon_e.x);
        chk("oy1",    bus1.oY,    mon_e.y);
        chk("osof0",  bus0.oSOF,  mon_e.sof);
        chk("osof1",  bus1.oSOF,  mon_e.sof);
      end
    end else begin
      chk("osof_idle0", bus0.oSOF, 0);
      chk("osof_idle1", bus1.oSOF, 0);
    end
  end

  initial begin
    for (int i = 0; i <= HMSK; i++) rst_h[i] = 1'b1;
    bus0.iRed = 0; bus0.iGreen = 0; bus0.iBlue = 0;
    bus0.iDVAL = 0; bus0.VGA_VS = 0; bus0.VGA_HS = 0;
    bus1.iRed = 0; bus1.iGreen = 0; bus1.iBlue = 0;
    bus1.iDVAL = 0; bus1.VGA_VS = 0; bus1.VGA_HS = 0;

    do_reset(L, L);

    // directed 4x4 flat-colour frame, then colour expansion extremes
    frame(4, 4, 0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0);
    frame(2, 2, 0, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b0);
    // iDVAL toggling inside lines
    frame(4, 3, 1, 8'h55, 8'hAA, 8'h0F, 1'b1, 1'b0);

    // accept on the first VS-high cycle (not yet active) and an empty line
    repeat (3) step(L, L, L, L, 8'h0, 8'h0, 8'h0);
    step(L, H, H, H, 8'h11, 8'h22, 8'h33);
    repeat (3) step(L, H, H, L, 8'h0, 8'h0, 8'h0);
    repeat (2) step(L, H, L, L, 8'h0, 8'h0, 8'h0);
    repeat (2) step(L, H, H, H, 8'h44, 8'h66, 8'h88);
    repeat (2) step(L, H, L, L, 8'h0, 8'h0, 8'h0);
    repeat (3) step(L, H, H, H, 8'h99, 8'hCC, 8'hEE);

    // reset in the middle of a frame at line 1, column 2
    repeat (3) step(L, L, L, L, 8'h0, 8'h0, 8'h0);
    repeat (2) step(L, H, L, L, 8'h0, 8'h0, 8'h0);
    repeat (4) step(L, H, H, H, 8'h21, 8'h42, 8'h84);
    repeat (2) step(L, H, L, L, 8'h0, 8'h0, 8'h0);
    repeat (2) step(L, H, H, H, 8'h13, 8'h57, 8'h9B);
    do_reset(H, H);
    repeat (6) step(L, H, H, H, 8'h77, 8'h88, 8'h99);
    repeat (2) step(L, H, L, L, 8'h0, 8'h0, 8'h0);
    repeat (4) step(L, H, H, H, 8'h77, 8'h88, 8'h99);
    frame(4, 2, 0, 8'h01, 8'h02, 8'h03, 1'b1, 1'b0);

    // randomized frames, some ending with HS and VS falling together
    for (int f = 0; f < 6; f++)
      frame(int'($urandom_range(1, 8)), int'($urandom_range(1, 5)), 2,
            8'h0, 8'h0, 8'h0, 1'b1, 1'($urandom_range(0, 1)));

    // over-long line: X saturates at X_MAX
    frame(XMAX + 3, 2, 0, 8'h0, 8'h0, 8'h0, 1'b1, 1'b0);

    repeat (6) step(L, L, L, L, 8'h0, 8'h0, 8'h0);
    @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
